// File: rtl/uart_frame_transmitter.sv
// uart_frame_transmitter
//
// Serialises bytes from a valid/ready producer onto a single UART line.
// Line format per frame: start(1), 8 data bits LSB first, parity (XOR of
// data), two stop bits (1). The line idles at 0. A one-entry holding buffer
// lets the next byte be queued while a frame is on the line, so consecutive
// frames follow each other with no idle gap.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_data        byte to send, sampled when i_valid && o_ready
//   i_valid       producer offers i_data
//   o_ready       holding buffer is empty
//   o_serial      registered UART line
//   o_busy        a frame is in progress or the buffer holds a byte
//   o_frame_done  one-cycle pulse in the last clk of the second stop bit
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per line bit (1..65535)
//   CNT_W         bit-period counter width, 2**CNT_W > CLKS_PER_BIT

module uart_frame_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_serial,
   output logic       o_busy,
   output logic       o_frame_done
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop1,
      StStop2
   } state_e;

   state_e             r_state;
   logic [7:0]         r_buf;
   logic               r_buf_full;
   logic [7:0]         r_shift;
   logic               r_parity;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_idx;
   logic               r_serial;
   logic               r_frame_done;

   logic               w_accept;
   logic               w_bit_end;
   logic               w_line;

   // The buffer can only be written while empty, so an accept never collides
   // with the drain of a full buffer into the shift register.
   assign w_accept  = i_valid && !r_buf_full;
   assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

   // Line level for the bit currently being timed by the FSM. It is
   // registered into r_serial, so the line trails the state by one clk.
   always_comb begin
      w_line = 1'b0;
      case (r_state)
         StIdle:   w_line = 1'b0;
         StStart:  w_line = 1'b1;
         StData:   w_line = r_shift[r_idx];
         StParity: w_line = r_parity;
         StStop1:  w_line = 1'b1;
         StStop2:  w_line = 1'b1;
         default:  w_line = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_buf        <= 8'h00;
         r_buf_full   <= 1'b0;
         r_shift      <= 8'h00;
         r_parity     <= 1'b0;
         r_cnt        <= '0;
         r_idx        <= 3'd0;
         r_serial     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_serial     <= w_line;
         // Registered alongside r_serial so the pulse lines up with the last
         // clk of the second stop bit as it appears on the line.
         r_frame_done <= (r_state == StStop2) && w_bit_end;

         if (w_accept) begin
            r_buf      <= i_data;
            r_buf_full <= 1'b1;
         end

         if (r_state == StIdle || w_bit_end) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         case (r_state)
            StIdle: begin
               if (r_buf_full) begin
                  r_state    <= StStart;
                  r_shift    <= r_buf;
                  r_parity   <= ^r_buf;
                  r_buf_full <= 1'b0;
               end
            end
            StStart: begin
               if (w_bit_end) begin
                  r_state <= StData;
                  r_idx   <= 3'd0;
               end
            end
            StData: begin
               if (w_bit_end) begin
                  if (r_idx == 3'd7) begin
                     r_state <= StParity;
                     r_idx   <= 3'd0;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            StParity: begin
               if (w_bit_end) begin
                  r_state <= StStop1;
               end
            end
            StStop1: begin
               if (w_bit_end) begin
                  r_state <= StStop2;
               end
            end
            StStop2: begin
               if (w_bit_end) begin
                  // A queued byte starts immediately: no idle gap between frames.
                  if (r_buf_full) begin
                     r_state    <= StStart;
                     r_shift    <= r_buf;
                     r_parity   <= ^r_buf;
                     r_buf_full <= 1'b0;
                  end else begin
                     r_state <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_ready      = !r_buf_full;
   assign o_serial     = r_serial;
   assign o_busy       = (r_state != StIdle) || r_buf_full;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// tb_uart_frame_transmitter
//
// Directed bench for uart_frame_transmitter. Two instances share clock and
// reset: dut1 runs at one clk per bit, dut4 at four clks per bit. Expected
// line patterns are hand-computed 12-bit constants written in line order
// (bit 11 = start bit, bit 0 = second stop bit).

module tb_uart_frame_transmitter;

   logic       clk;
   logic       rst;
   logic [7:0] d1, d4;
   logic       v1, v4;
   logic       rdy1, ser1, busy1, fd1;
   logic       rdy4, ser4, busy4, fd4;

   int n_cmp = 0;
   int n_bad = 0;

   uart_frame_transmitter #(
      .CLKS_PER_BIT (1),
      .CNT_W        (16)
   ) dut1 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_data       (d1),
      .i_valid      (v1),
      .o_ready      (rdy1),
      .o_serial     (ser1),
      .o_busy       (busy1),
      .o_frame_done (fd1)
   );

   uart_frame_transmitter #(
      .CLKS_PER_BIT (4),
      .CNT_W        (16)
   ) dut4 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_data       (d4),
      .i_valid      (v4),
      .o_ready      (rdy4),
      .o_serial     (ser4),
      .o_busy       (busy4),
      .o_frame_done (fd4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  data;
      logic [11:0] line;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one byte on dut1 so that it is accepted at the next edge.
   task automatic send1(input logic [7:0] d);
      d1 = d;
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      d1 = 8'($urandom);
   endtask

   // Independent receiver model of the line format.
   task automatic rx_decode(input logic [11:0] line, output logic [7:0] b,
                            output logic start_ok, output logic par_err,
                            output logic stop_err);
      for (int i = 0; i < 8; i++) b[i] = line[10-i];
      start_ok = line[11];
      par_err  = ((^b) != line[2]);
      stop_err = (line[1:0] != 2'b11);
   endtask

   // Full single-frame check on dut1: accept, latency, line, pulse, return to idle.
   task automatic run_frame1(input logic [7:0] d, input logic [11:0] exp_line);
      logic [11:0] line;
      logic [11:0] fd;
      logic [7:0]  rb;
      logic        s_ok, p_err, st_err;
      send1(d);
      check("ready_low_after_accept", rdy1, 1'b0);
      check("busy_after_accept", busy1, 1'b1);
      check("line_idle_at_accept", ser1, 1'b0);
      tick();
      check("line_idle_one_after_accept", ser1, 1'b0);
      for (int k = 0; k < 12; k++) begin
         tick();
         line[11-k] = ser1;
         fd[11-k]   = fd1;
      end
      check("frame_line", line, exp_line);
      check("frame_done_pulse", fd, 12'h001);
      rx_decode(line, rb, s_ok, p_err, st_err);
      check("rx_byte", rb, d);
      check("rx_errors", {s_ok, p_err, st_err}, 3'b100);
      tick();
      check("idle_after_frame", {ser1, rdy1, busy1, fd1}, 4'b0100);
   endtask

   initial begin
      logic [23:0] l24;
      logic [23:0] f24;
      logic [47:0] l48;
      logic [47:0] f48;
      logic [47:0] e48;
      logic [11:0] c12;
      logic [4:0]  l5;

      vecs[0] = '{data: 8'hA5, line: 12'hD2B};
      vecs[1] = '{data: 8'h00, line: 12'h803};
      vecs[2] = '{data: 8'h80, line: 12'h80F};
      vecs[3] = '{data: 8'hFF, line: 12'hFFB};
      vecs[4] = '{data: 8'h55, line: 12'hD53};
      vecs[5] = '{data: 8'h3C, line: 12'h9E3};
      vecs[6] = '{data: 8'h07, line: 12'hF07};

      rst = 1'b1;
      v1  = 1'b0;
      v4  = 1'b0;
      d1  = 8'h00;
      d4  = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      check("reset_dut1", {ser1, rdy1, busy1, fd1}, 4'b0100);
      check("reset_dut4", {ser4, rdy4, busy4, fd4}, 4'b0100);

      // Idle with valid low: nothing may move.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_hold", {ser1, rdy1, busy1, fd1, ser4, rdy4, busy4, fd4}, 8'b0100_0100);
      end

      // Table of single frames at one clk per bit.
      for (int i = 0; i < 7; i++) begin
         run_frame1(vecs[i].data, vecs[i].line);
      end

      // 0x07 at four clks per bit: 48-cycle frame, parity 1.
      d4 = 8'h07;
      v4 = 1'b1;
      tick();
      v4 = 1'b0;
      check("cpb4_ready_low", rdy4, 1'b0);
      tick();
      check("cpb4_line_idle_latency", ser4, 1'b0);
      c12 = 12'hF07;
      for (int k = 0; k < 48; k++) e48[47-k] = c12[11-(k/4)];
      for (int k = 0; k < 48; k++) begin
         tick();
         l48[47-k] = ser4;
         f48[47-k] = fd4;
         if (k == 0) check("cpb4_busy", busy4, 1'b1);
      end
      check("cpb4_line", l48, e48);
      check("cpb4_frame_done", f48, 48'h1);
      tick();
      check("cpb4_idle_after", {ser4, rdy4, busy4, fd4}, 4'b0100);

      // Back-to-back 0x01 then 0xFF with valid held high.
      d1 = 8'h01;
      v1 = 1'b1;
      tick();
      check("b2b_ready_full", rdy1, 1'b0);
      d1 = 8'hFF;
      tick();
      check("b2b_ready_drained", rdy1, 1'b1);
      tick();
      v1 = 1'b0;
      check("b2b_ready_second", rdy1, 1'b0);
      l24[23] = ser1;
      f24[23] = fd1;
      for (int k = 1; k < 24; k++) begin
         tick();
         l24[23-k] = ser1;
         f24[23-k] = fd1;
         if (k == 10) check("b2b_ready_held", rdy1, 1'b0);
         if (k == 11) check("b2b_ready_freed", rdy1, 1'b1);
         if (k == 12) check("b2b_busy_no_gap", busy1, 1'b1);
      end
      check("b2b_line", l24, {12'hC07, 12'hFFB});
      check("b2b_frame_done", f24, 24'h001001);
      tick();
      check("b2b_idle_after", {ser1, rdy1, busy1, fd1}, 4'b0100);

      // Reset during data bit 3 of 0x3C, then a clean 0x55 frame.
      send1(8'h3C);
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         l5[4-k] = ser1;
      end
      check("rst_prefix_line", l5, 5'b10011);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_frame", {ser1, rdy1, busy1, fd1}, 4'b0100);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_no_stop_bits", {ser1, fd1, busy1}, 3'b000);
      end
      run_frame1(8'h55, 12'hD53);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
